// File: rtl/truth_table_sweeper_if.sv
// Bus between a start/done requester, the sweeper and the datapath under test.
// The master side requests sweeps and supplies the datapath output; the slave
// side is the sweeper itself.
interface truth_table_sweeper_if #(
   parameter int unsigned N_IN = 5
);
   logic                 start;
   logic                 abort;
   logic                 f_in;
   logic [N_IN-1:0]      vec_out;
   logic                 busy;
   logic                 done;
   logic [2**N_IN-1:0]   table_out;
   logic [N_IN:0]        ones_cnt;

   modport master (
      output start, abort, f_in,
      input  vec_out, busy, done, table_out, ones_cnt
   );

   modport slave (
      input  start, abort, f_in,
      output vec_out, busy, done, table_out, ones_cnt
   );
endinterface

// File: rtl/truth_table_sweeper.sv
// Exhaustive truth-table sweeper: walks every input vector of an N_IN-input
// combinational block in ascending order, holds each one SETTLE cycles, then
// samples the block output into table_out and keeps a running count of ones.
module truth_table_sweeper #(
   parameter int unsigned N_IN   = 5,
   parameter int unsigned SETTLE = 1
) (
   input logic                  clk,
   input logic                  rst_n,
   truth_table_sweeper_if.slave bus
);
   localparam int unsigned NVec = 2 ** N_IN;

   typedef enum logic [1:0] {StIdle, StApply, StSample, StDone} state_e;

   localparam logic [N_IN-1:0] LastVec  = '1;
   localparam logic [N_IN-1:0] VecOne   = N_IN'(1);
   localparam logic [3:0]      SettleLd = 4'(SETTLE);
   // With no settle time the vector is sampled on the cycle after it is driven.
   localparam state_e          HoldSt   = (SETTLE > 0) ? StApply : StSample;

   state_e            state_q;
   logic [3:0]        cnt_q;
   logic [N_IN-1:0]   vec_q;
   logic [NVec-1:0]   table_q;
   logic [N_IN:0]     ones_q;
   logic              busy_q;
   logic              done_q;

   // Sweep FSM; every output is a register updated here.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= StIdle;
         cnt_q   <= '0;
         vec_q   <= '0;
         table_q <= '0;
         ones_q  <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         done_q <= 1'b0;
         unique case (state_q)
            StIdle: begin
               // abort outranks start, so start=abort=1 does nothing
               if (bus.start && !bus.abort) begin
                  vec_q   <= '0;
                  table_q <= '0;
                  ones_q  <= '0;
                  cnt_q   <= SettleLd;
                  busy_q  <= 1'b1;
                  state_q <= HoldSt;
               end
            end
            StApply: begin
               if (bus.abort) begin
                  table_q <= '0;
                  ones_q  <= '0;
                  busy_q  <= 1'b0;
                  state_q <= StIdle;
               end else begin
                  cnt_q <= cnt_q - 4'd1;
                  if (cnt_q == 4'd1) begin
                     state_q <= StSample;
                  end
               end
            end
            StSample: begin
               if (bus.abort) begin
                  // sample in flight is dropped along with the partial table
                  table_q <= '0;
                  ones_q  <= '0;
                  busy_q  <= 1'b0;
                  state_q <= StIdle;
               end else begin
                  table_q[vec_q] <= bus.f_in;
                  ones_q         <= ones_q + (N_IN + 1)'(bus.f_in);
                  if (vec_q == LastVec) begin
                     busy_q  <= 1'b0;
                     done_q  <= 1'b1;
                     state_q <= StDone;
                  end else begin
                     vec_q   <= vec_q + VecOne;
                     cnt_q   <= SettleLd;
                     state_q <= HoldSt;
                  end
               end
            end
            StDone: begin
               state_q <= StIdle;
            end
            default: begin
               state_q <= StIdle;
            end
         endcase
      end
   end

   assign bus.vec_out   = vec_q;
   assign bus.busy      = busy_q;
   assign bus.done      = done_q;
   assign bus.table_out = table_q;
   assign bus.ones_cnt  = ones_q;
endmodule
